if_id_skid_stage: RTL and testbench

- Parametrised IF/ID pipeline stage between fetch and decode. Registers the fetched instruction and its address, and decodes the fixed MIPS field slices for the decode stage.
- Adds a valid/ready handshake toward fetch, a 1-entry skid buffer so an instruction presented during a hazard stall is captured rather than lost, flush-to-bubble, and a saturating stall/flush cycle counter.
- Stall (hazard) holds the stage contents; it does not insert a bubble.

---
 rtl/if_id_skid_stage_if.sv | 24 ++
 rtl/if_id_skid_stage.sv | 117 +++++++++++
 tb/tb_if_id_skid_stage.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_skid_stage_if.sv
// Fetch-to-IF/ID handshake bundle: fetch drives a valid address/instruction
// pair, and the stage answers with ready.
interface if_id_skid_stage_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [ADDR_W-1:0] inst_addr_i;
  logic [31:0]       inst_i;

  modport master (
    output in_valid_i,
    output inst_addr_i,
    output inst_i,
    input  in_ready_o
  );

  modport slave (
    input  in_valid_i,
    input  inst_addr_i,
    input  inst_i,
    output in_ready_o
  );
endinterface

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with a valid/ready handshake, a 1-entry skid buffer,
// flush-to-bubble, MIPS field slicing and a saturating stall/flush counter.
module if_id_skid_stage #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_INST = 32'hFC00_0000,
  parameter int          CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  if_id_skid_stage_if.slave   fetch,
  input  logic                stall_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  output logic [ADDR_W-1:0]   inst_addr_o,
  output logic [31:0]         inst_o,
  output logic [5:0]          op_o,
  output logic [4:0]          rs_o,
  output logic [4:0]          rt_o,
  output logic [4:0]          rd_o,
  output logic [15:0]         imm_o,
  output logic [25:0]         jaddr_o,
  output logic [CNT_W-1:0]    bubble_cnt_o
);

  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [31:0]       r_out_inst;
  logic              r_skid_valid;
  logic [ADDR_W-1:0] r_skid_addr;
  logic [31:0]       r_skid_inst;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_out_valid;
  logic [ADDR_W-1:0] w_out_addr;
  logic [31:0]       w_out_inst;
  logic              w_skid_valid;
  logic [ADDR_W-1:0] w_skid_addr;
  logic [31:0]       w_skid_inst;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_accept;

  // Ready comes straight from the skid flop, so stall/flush never reach it combinationally.
  assign fetch.in_ready_o = ~r_skid_valid;
  assign w_accept         = fetch.in_valid_i & ~r_skid_valid;

  always_comb begin
    w_out_valid  = r_out_valid;
    w_out_addr   = r_out_addr;
    w_out_inst   = r_out_inst;
    w_skid_valid = r_skid_valid;
    w_skid_addr  = r_skid_addr;
    w_skid_inst  = r_skid_inst;
    w_cnt        = r_cnt;

    if (flush_i) begin
      w_out_valid  = 1'b0;
      w_out_addr   = '0;
      w_out_inst   = NOP_INST;
      w_skid_valid = 1'b0;
    end else if (stall_i) begin
      if (w_accept) begin
        w_skid_valid = 1'b1;
        w_skid_addr  = fetch.inst_addr_i;
        w_skid_inst  = fetch.inst_i;
      end
    end else if (r_skid_valid) begin
      w_out_valid  = 1'b1;
      w_out_addr   = r_skid_addr;
      w_out_inst   = r_skid_inst;
      w_skid_valid = 1'b0;
    end else if (w_accept) begin
      w_out_valid  = 1'b1;
      w_out_addr   = fetch.inst_addr_i;
      w_out_inst   = fetch.inst_i;
    end else begin
      w_out_valid  = 1'b0;
      w_out_addr   = '0;
      w_out_inst   = NOP_INST;
    end

    if ((stall_i | flush_i) && (r_cnt != {CNT_W{1'b1}})) begin
      w_cnt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_out_valid  <= 1'b0;
      r_out_addr   <= '0;
      r_out_inst   <= NOP_INST;
      r_skid_valid <= 1'b0;
      r_skid_addr  <= '0;
      r_skid_inst  <= NOP_INST;
      r_cnt        <= '0;
    end else begin
      r_out_valid  <= w_out_valid;
      r_out_addr   <= w_out_addr;
      r_out_inst   <= w_out_inst;
      r_skid_valid <= w_skid_valid;
      r_skid_addr  <= w_skid_addr;
      r_skid_inst  <= w_skid_inst;
      r_cnt        <= w_cnt;
    end
  end

  assign out_valid_o  = r_out_valid;
  assign inst_addr_o  = r_out_addr;
  assign inst_o       = r_out_inst;
  assign op_o         = r_out_inst[31:26];
  assign rs_o         = r_out_inst[25:21];
  assign rt_o         = r_out_inst[20:16];
  assign rd_o         = r_out_inst[15:11];
  assign imm_o        = r_out_inst[15:0];
  assign jaddr_o      = r_out_inst[25:0];
  assign bubble_cnt_o = r_cnt;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed plus random checks of the IF/ID skid stage against an in-order
// instruction scoreboard, and a narrow-counter instance for saturation.
module tb_if_id_skid_stage;

  localparam logic [31:0] NOP = 32'hFC00_0000;

  logic clk;
  logic rst_n;
  logic stall, flush;
  logic stall2;

  logic        outValid;
  logic [31:0] instAddr, inst;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] jaddr;
  logic [15:0] bubbleCnt;

  logic        outValid2;
  logic [31:0] instAddr2, inst2;
  logic [5:0]  op2;
  logic [4:0]  rs2, rt2, rd2;
  logic [15:0] imm2;
  logic [25:0] jaddr2;
  logic [1:0]  bubbleCnt2;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] sb[$];
  logic        expValid;
  logic [31:0] expAddr, expInst;
  logic        expSkid;
  logic [15:0] expCnt;

  if_id_skid_stage_if #(.ADDR_W(32)) fetchIf ();
  if_id_skid_stage_if #(.ADDR_W(32)) fetchIf2 ();

  if_id_skid_stage #(.ADDR_W(32), .NOP_INST(NOP), .CNT_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .fetch(fetchIf.slave),
    .stall_i(stall), .flush_i(flush),
    .out_valid_o(outValid), .inst_addr_o(instAddr), .inst_o(inst),
    .op_o(op), .rs_o(rs), .rt_o(rt), .rd_o(rd), .imm_o(imm), .jaddr_o(jaddr),
    .bubble_cnt_o(bubbleCnt)
  );

  if_id_skid_stage #(.ADDR_W(32), .NOP_INST(NOP), .CNT_W(2)) dutNarrow (
    .clk_i(clk), .rst_n_i(rst_n), .fetch(fetchIf2.slave),
    .stall_i(stall2), .flush_i(1'b0),
    .out_valid_o(outValid2), .inst_addr_o(instAddr2), .inst_o(inst2),
    .op_o(op2), .rs_o(rs2), .rt_o(rt2), .rd_o(rd2), .imm_o(imm2), .jaddr_o(jaddr2),
    .bubble_cnt_o(bubbleCnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    sb.delete();
    expValid = 1'b0;
    expAddr  = '0;
    expInst  = NOP;
    expSkid  = 1'b0;
    expCnt   = '0;
  endtask

  task automatic checkState();
    checkOutput("inst", {32'd0, inst}, {32'd0, expInst});
    checkOutput("addr", {32'd0, instAddr}, {32'd0, expAddr});
    checkOutput("valid", {63'd0, outValid}, {63'd0, expValid});
    checkOutput("ready", {63'd0, fetchIf.in_ready_o}, {63'd0, ~expSkid});
    checkOutput("cnt", {48'd0, bubbleCnt}, {48'd0, expCnt});
    checkOutput("op", {58'd0, op}, {58'd0, expInst[31:26]});
    checkOutput("rs", {59'd0, rs}, {59'd0, expInst[25:21]});
    checkOutput("rt", {59'd0, rt}, {59'd0, expInst[20:16]});
    checkOutput("rd", {59'd0, rd}, {59'd0, expInst[15:11]});
    checkOutput("imm", {48'd0, imm}, {48'd0, expInst[15:0]});
    checkOutput("jaddr", {38'd0, jaddr}, {38'd0, expInst[25:0]});
  endtask

  // Drives one cycle at the falling edge, predicts the stage after the rising edge, and checks it.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] i,
                               input logic st, input logic fl);
    logic        acc;
    logic [63:0] ent;
    fetchIf.in_valid_i  = v;
    fetchIf.inst_addr_i = a;
    fetchIf.inst_i      = i;
    stall = st;
    flush = fl;
    #1;
    acc = v && fetchIf.in_ready_o;
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
      expValid = 1'b0;
      expAddr  = '0;
      expInst  = NOP;
      expSkid  = 1'b0;
    end else if (st) begin
      if (acc) begin
        sb.push_back({a, i});
        expSkid = 1'b1;
      end
    end else begin
      if (acc) sb.push_back({a, i});
      expSkid = 1'b0;
      if (sb.size() > 0) begin
        ent      = sb.pop_front();
        expValid = 1'b1;
        expAddr  = ent[63:32];
        expInst  = ent[31:0];
      end else begin
        expValid = 1'b0;
        expAddr  = '0;
        expInst  = NOP;
      end
    end
    if ((st || fl) && expCnt != 16'hFFFF) expCnt++;
    checkState();
    @(negedge clk);
  endtask

  initial begin
    int expSeq[6];
    expSeq = '{1, 2, 3, 3, 3, 3};
    rst_n  = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    stall2 = 1'b0;
    fetchIf.in_valid_i   = 1'b0;
    fetchIf.inst_addr_i  = '0;
    fetchIf.inst_i       = '0;
    fetchIf2.in_valid_i  = 1'b0;
    fetchIf2.inst_addr_i = '0;
    fetchIf2.inst_i      = '0;
    resetModel();

    #12;
    checkOutput("rst_inst", {32'd0, inst}, {32'd0, 32'hFC00_0000});
    checkOutput("rst_valid", {63'd0, outValid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkState();

    // Streaming without stalls
    applyStimulus(1'b1, 32'h0, 32'h8C22_0004, 1'b0, 1'b0);
    checkOutput("lw_op", {58'd0, op}, 64'h23);
    checkOutput("lw_rs", {59'd0, rs}, 64'd1);
    checkOutput("lw_rt", {59'd0, rt}, 64'd2);
    checkOutput("lw_imm", {48'd0, imm}, 64'h4);
    applyStimulus(1'b1, 32'h4, 32'h0022_1820, 1'b0, 1'b0);
    checkOutput("add_rd", {59'd0, rd}, 64'd3);
    checkOutput("add_addr", {32'd0, instAddr}, 64'h4);

    // Stall captures the presented instruction in the skid
    applyStimulus(1'b1, 32'h8, 32'h8C22_0004, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC, 32'h0022_1820, 1'b1, 1'b0);
    checkOutput("stall_hold", {32'd0, inst}, 64'h8C22_0004);
    checkOutput("stall_ready", {63'd0, fetchIf.in_ready_o}, 64'd0);
    applyStimulus(1'b1, 32'h10, 32'h1111_1111, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h10, 32'h1111_1111, 1'b0, 1'b0);
    checkOutput("skid_out", {32'd0, inst}, 64'h0022_1820);
    checkOutput("skid_ready", {63'd0, fetchIf.in_ready_o}, 64'd1);
    applyStimulus(1'b1, 32'h10, 32'h1111_1111, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush with the skid full and input valid
    applyStimulus(1'b1, 32'h14, 32'h2222_2222, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h18, 32'h3333_3333, 1'b0, 1'b1);
    checkOutput("flush_valid", {63'd0, outValid}, 64'd0);
    checkOutput("flush_inst", {32'd0, inst}, 64'hFC00_0000);
    checkOutput("flush_ready", {63'd0, fetchIf.in_ready_o}, 64'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("flush_drop", {63'd0, (inst == 32'h2222_2222)}, 64'd0);

    // Flush and stall together: flush wins, counter moves by one
    applyStimulus(1'b1, 32'h20, 32'h5555_5555, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1C, 32'h4444_4444, 1'b1, 1'b1);
    checkOutput("fs_inst", {32'd0, inst}, 64'hFC00_0000);
    checkOutput("fs_cnt", {48'd0, bubbleCnt}, 64'd5);

    // Random traffic
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 32'h100 + 32'(k) * 4, $urandom,
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset in the middle of a stall, between clock edges
    fetchIf.in_valid_i  = 1'b1;
    fetchIf.inst_addr_i = 32'h200;
    fetchIf.inst_i      = 32'h1234_5678;
    stall = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_inst", {32'd0, inst}, 64'hFC00_0000);
    checkOutput("arst_valid", {63'd0, outValid}, 64'd0);
    checkOutput("arst_ready", {63'd0, fetchIf.in_ready_o}, 64'd1);
    checkOutput("arst_cnt", {48'd0, bubbleCnt}, 64'd0);
    resetModel();
    stall = 1'b0;
    fetchIf.in_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h300, 32'h0C00_0010, 1'b0, 1'b0);

    // Narrow counter saturation
    checkOutput("cnt2_start", {62'd0, bubbleCnt2}, 64'd0);
    for (int k = 0; k < 6; k++) begin
      stall2 = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("cnt2_sat", {62'd0, bubbleCnt2}, 64'(expSeq[k]));
      @(negedge clk);
    end
    stall2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
